// File: rtl/apb_pkg.sv
// Shared types and constants for the APB interconnect: FSM encoding,
// default-slave response data and the default UART/SRAM address map.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DEFSLV
  } apb_state_e;

  localparam int DEF_RDATA = 0;

  localparam logic [31:0] UART_BASE = 32'h0000_0400;
  localparam logic [31:0] UART_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] SRAM_BASE = 32'h0000_0000;
  localparam logic [31:0] SRAM_MASK = 32'h0000_0000;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational base/mask address decoder; lowest-index hit wins on overlap.
module apb_addr_decode #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SLAVES = 2,
  parameter int IDX_WIDTH  = 1,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] BASE_ADDRS = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] ADDR_MASKS = '0
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit,
  output logic [IDX_WIDTH-1:0]  idx
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    hit = 1'b0;
    idx = '0;
    // Scan from the top down so the lowest matching index is the last one written.
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & ADDR_MASKS[i*ADDR_WIDTH +: ADDR_WIDTH]) == BASE_ADDRS[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit = 1'b1;
        idx = IDX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/apb_interconnect.sv
// APB 1-to-N interconnect: routes the requester to the completer latched at
// SETUP, answers unmapped addresses itself and bounds stalled transfers.
module apb_interconnect
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 2,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] BASE_ADDRS = {SRAM_BASE, UART_BASE},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] ADDR_MASKS = {SRAM_MASK, UART_MASK},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             pclk,
  input  logic                             presetn,
  input  logic [ADDR_WIDTH-1:0]            paddr,
  input  logic                             psel,
  input  logic                             penable,
  output logic                             pready,
  output logic                             perr,
  output logic [DATA_WIDTH-1:0]            prdata,
  output logic [NUM_SLAVES-1:0]            s_psel,
  output logic [NUM_SLAVES-1:0]            s_penable,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_prdata,
  input  logic [NUM_SLAVES-1:0]            s_pready,
  input  logic [NUM_SLAVES-1:0]            s_perr
);

  localparam int IDX_WIDTH = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;

  apb_state_e           state;
  logic [IDX_WIDTH-1:0] tgt_idx;
  logic                 tgt_def;
  logic [CNT_WIDTH-1:0] wait_cnt;

  logic                 dec_hit;
  logic [IDX_WIDTH-1:0] dec_idx;

  logic setup;
  logic acc_active;
  logic def_active;
  logic tgt_ready;
  logic timeout_hit;

  apb_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SLAVES (NUM_SLAVES),
    .IDX_WIDTH  (IDX_WIDTH),
    .BASE_ADDRS (BASE_ADDRS),
    .ADDR_MASKS (ADDR_MASKS)
  ) u_decode (
    .addr (paddr),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  // SETUP select is combinational, so it is gated by reset to keep s_psel low in reset.
  assign setup       = (state == IDLE) && psel && !penable && presetn;
  assign acc_active  = (state == ACCESS) && psel;
  assign def_active  = (state == DEFSLV) && psel;
  assign tgt_ready   = s_pready[tgt_idx];
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == TIMEOUT_VAL);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state    <= IDLE;
      tgt_idx  <= '0;
      tgt_def  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (setup) begin
            tgt_idx <= dec_idx;
            tgt_def <= !dec_hit;
            state   <= dec_hit ? ACCESS : DEFSLV;
          end
        end
        ACCESS: begin
          if (!psel || tgt_ready || timeout_hit) begin
            state    <= IDLE;
            wait_cnt <= '0;
          end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DEFSLV: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    pready    = 1'b0;
    perr      = 1'b0;
    prdata    = DATA_WIDTH'(DEF_RDATA);
    s_psel    = '0;
    s_penable = '0;
    if (acc_active && !tgt_def) begin
      if (timeout_hit) begin
        pready = 1'b1;
        perr   = 1'b1;
      end else begin
        s_psel    = NUM_SLAVES'(1) << tgt_idx;
        s_penable = NUM_SLAVES'(1) << tgt_idx;
        pready    = tgt_ready;
        perr      = tgt_ready && s_perr[tgt_idx];
        if (tgt_ready) prdata = s_prdata[tgt_idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (def_active) begin
      pready = 1'b1;
      perr   = 1'b1;
    end else if (setup && dec_hit) begin
      s_psel = NUM_SLAVES'(1) << dec_idx;
    end
  end

endmodule

// File: doc/apb_interconnect.md
Name: apb_interconnect

Overview:
Parametrised APB interconnect that routes one APB requester to NUM_SLAVES completers using a base/mask address map per completer. It latches the decoded target at SETUP, so routing stays stable even if paddr moves during ACCESS. It answers unmapped addresses from an internal default slave and bounds stalled transfers with a timeout. It sits between the CPU-side APB master and the SRAM, UART and future peripherals; address, write data, pwrite and pstb are broadcast to all completers by the top level.

Parameters:
ADDR_WIDTH, 32, address width.
DATA_WIDTH, 32, data width.
NUM_SLAVES, 2, number of completers (1..16).
BASE_ADDRS, {32'h0000_0000, 32'h0000_0400}, packed; completer i base at [i*ADDR_WIDTH +: ADDR_WIDTH]. Default: 0 = UART, 1 = SRAM.
ADDR_MASKS, {32'h0000_0000, 32'hFFFF_FFFC}, packed, same layout; completer i hits when (paddr & MASK_i) == BASE_i.
TIMEOUT_CYCLES, 255, ACCESS wait cycles before the forced error; 0 disables the timeout.

Ports:
pclk  in  1  clock
presetn  in  1  asynchronous active-low reset
paddr  in  ADDR_WIDTH  requester address
psel  in  1  requester select
penable  in  1  requester enable
pready  out  1  transfer complete to requester
perr  out  1  transfer error to requester
prdata  out  DATA_WIDTH  read data to requester
s_psel  out  NUM_SLAVES  per-completer select
s_penable  out  NUM_SLAVES  per-completer enable
s_prdata  in  NUM_SLAVES*DATA_WIDTH  completer read data, packed by index
s_pready  in  NUM_SLAVES  completer ready
s_perr  in  NUM_SLAVES  completer error

Behaviour:
- Clock and reset: single clock pclk; reset presetn is asynchronous, active-low.
- Reset state: FSM in IDLE, latched target cleared, wait counter 0. pready, perr, prdata, s_psel and s_penable are all 0 while presetn is low and immediately on its assertion.
- Address decode: combinational. The lowest-index hit wins on overlap. No hit selects the default slave (DEF).
- FSM states: IDLE, ACCESS, DEFSLV.
- IDLE:
  - psel=1, penable=0 is the SETUP cycle. s_psel[hit] asserts in this same cycle (combinational); the hit index is registered at the edge.
  - Next state is ACCESS on a hit, DEFSLV on no hit.
  - penable=1 without a preceding SETUP is ignored: no s_psel, pready=0.
- ACCESS:
  - s_psel[t] and s_penable[t] asserted for the latched target t only.
  - pready = s_pready[t]; perr = s_perr[t] & s_pready[t]; prdata = s_prdata[t] when s_pready[t], else 0. Errors from non-selected completers are never forwarded.
  - Wait counter increments on each ACCESS cycle with s_pready[t]=0.
  - When the counter equals TIMEOUT_CYCLES (non-zero), that cycle drives pready=1, perr=1, prdata=0 and s_psel[t]=0, and the transfer ends. The response therefore falls on ACCESS cycle TIMEOUT_CYCLES+1.
- DEFSLV: single ACCESS cycle with no s_psel; pready=1, perr=1, prdata=0.
- On completion (pready=1):
  - counter clears;
  - with psel=1, penable=0 on the next cycle, that cycle is a fresh SETUP (back-to-back, re-decoded);
  - with psel=0, return to IDLE.
- psel dropping mid-ACCESS: abort, return to IDLE, counter clears, no response issued.
- Latency:
  - zero-wait completer: 2 cycles per transfer (SETUP + ACCESS), no added cycles;
  - unmapped address: 2 cycles;
  - timed-out transfer: 1 + TIMEOUT_CYCLES + 1 cycles.
- Widths:
  - counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1;
  - latched target is $clog2(NUM_SLAVES) bits (minimum 1) plus a DEF flag;
  - counter saturates and never wraps.

Decomposition:
- Shared package apb_pkg:
  - FSM state enum {IDLE, ACCESS, DEFSLV};
  - DEF_RDATA = 0;
  - default UART/SRAM base and mask constants.
- One sub-module, apb_addr_decode: purely combinational priority decoder, output {hit, index}, parametrised on NUM_SLAVES/BASE_ADDRS/ADDR_MASKS.

Test Plan:
- Default map, write paddr=0x400, UART s_pready low for 2 ACCESS cycles -> only s_psel[0] high; pready=1 on 3rd ACCESS cycle; perr=0; s_psel[1] never asserted.
- Default map, read paddr=0x1000, SRAM zero-wait, s_prdata[1]=0xDEAD_BEEF -> prdata=0xDEAD_BEEF with pready=1 in the 2nd cycle; paddr changed to 0x400 during ACCESS does not move s_psel.
- NUM_SLAVES=1, BASE=0x400, MASK=0xFFFF_FFFC, access paddr=0x800 -> s_psel=0 throughout; pready=1, perr=1, prdata=0 in the ACCESS cycle.
- TIMEOUT_CYCLES=4, completer never ready -> pready=1, perr=1 on ACCESS cycle 5; s_psel drops that cycle; next transfer routes normally.
- s_perr[0] held at 1, transfer to SRAM with s_perr[1]=0 -> perr=0; then s_perr[1]=1 with s_pready[1]=1 -> perr=1.
- presetn pulled low mid-ACCESS with 2 back-to-back transfers queued -> all outputs 0 asynchronously; after release FSM is in IDLE, and the next SETUP decodes cleanly.
